// File: rtl/loadable_counter_sequencer_pkg.sv
// Shared types and constants for the loadable counter sequencer.
// Imported by the controller and by anything that needs to decode its state.
package loadable_counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/parameterized_loadable_counter.sv
// Loadable up-counter: load has priority over enable; wraps naturally at 2^WIDTH.
module parameterized_loadable_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             enable,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_d, count_q;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = data_in;
    end else if (enable) begin
      count_d = count_q + ONE;
    end
  end

  // NOTE: state registers use non-blocking (<=) so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/loadable_counter_sequencer.sv
// Interval timer controller: accepts a job over valid/ready, sequences the loadable
// counter through load/run periods, and emits tick per period and done per one-shot job.
module loadable_counter_sequencer
  import loadable_counter_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic             cfg_periodic,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             pause,
  input  logic             abort,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic [WIDTH-1:0] count,
  output logic [REP_W-1:0] rep_left
);

  localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             periodic_q, periodic_d;
  logic [REP_W-1:0] rep_left_q, rep_left_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic             reload_hit;
  logic             ctr_load;
  logic             ctr_enable;
  logic [WIDTH-1:0] ctr_count;

  // Abort freezes the counter as well as the FSM, so count holds where it was.
  assign reload_hit = (state_q == RUN) && !pause && !abort && (ctr_count == limit_q);
  assign ctr_load   = ((state_q == LOAD) && !abort) || reload_hit;
  assign ctr_enable = (state_q == RUN) && !pause && !abort;

  parameterized_loadable_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (ctr_load),
    .enable (ctr_enable),
    .data_in(start_q),
    .count  (ctr_count)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    limit_d    = limit_q;
    periodic_d = periodic_q;
    rep_left_d = rep_left_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          start_d    = cfg_start;
          limit_d    = cfg_limit;
          periodic_d = cfg_periodic;
          rep_left_d = (cfg_reps == '0) ? REP_ONE : cfg_reps;
          state_d    = LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (reload_hit) begin
          tick_d = 1'b1;
          if (periodic_q == MODE_ONESHOT) begin
            rep_left_d = rep_left_q - REP_ONE;
            if (rep_left_q == REP_ONE) begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // reload_hit already excludes abort, so only the state needs overriding here.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      start_q    <= '0;
      limit_q    <= '0;
      periodic_q <= MODE_ONESHOT;
      rep_left_q <= '0;
      tick_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      limit_q    <= limit_d;
      periodic_q <= periodic_d;
      rep_left_q <= rep_left_d;
      tick_q     <= tick_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign tick      = tick_q;
  assign done      = done_q;
  assign count     = ctr_count;
  assign rep_left  = rep_left_q;

endmodule

// File: tb/tb_loadable_counter_sequencer.sv
// Self-checking bench for loadable_counter_sequencer: directed vectors, corner sequences,
// and randomized traffic compared against a job-level reference model.
module tb_loadable_counter_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_start;
  logic [7:0] cfg_limit;
  logic       cfg_periodic;
  logic [3:0] cfg_reps;
  logic       pause;
  logic       abort;
  logic       busy;
  logic       tick;
  logic       done;
  logic [7:0] count;
  logic [3:0] rep_left;

  int n_checks = 0;
  int n_fail   = 0;

  loadable_counter_sequencer #(.WIDTH(8), .REP_W(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_start   (cfg_start),
    .cfg_limit   (cfg_limit),
    .cfg_periodic(cfg_periodic),
    .cfg_reps    (cfg_reps),
    .pause       (pause),
    .abort       (abort),
    .busy        (busy),
    .tick        (tick),
    .done        (done),
    .count       (count),
    .rep_left    (rep_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic pause;
    logic abort;
    int   exp_count;
    logic exp_tick;
    logic exp_done;
    logic exp_busy;
    int   exp_rep;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 50 && !cfg_ready; i++) cycle();
    check("wait_ready", cfg_ready, 1);
  endtask

  task automatic drive_cfg(input int s, input int l, input int p, input int r);
    cfg_valid    = 1'b1;
    cfg_start    = 8'(s);
    cfg_limit    = 8'(l);
    cfg_periodic = 1'(p);
    cfg_reps     = 4'(r);
  endtask

  // Reference model: a job is a sequence of periods of ((limit-start) mod 256)+1 unpaused
  // cycles, preceded by one load cycle and (one-shot only) followed by one completion cycle.
  int m_count, m_start, m_limit, m_left;
  bit m_periodic, m_job, m_need_load, m_wrap_up, m_tick, m_done;

  function automatic void model_reset();
    m_count = 0; m_start = 0; m_limit = 0; m_left = 0;
    m_periodic = 0; m_job = 0; m_need_load = 0; m_wrap_up = 0; m_tick = 0; m_done = 0;
  endfunction

  function automatic void model_edge(input bit v, input int s, input int l, input bit p,
                                     input int r, input bit ps, input bit ab);
    m_tick = 0;
    m_done = 0;
    if (!m_job) begin
      if (v) begin
        m_job = 1; m_need_load = 1; m_wrap_up = 0;
        m_start = s; m_limit = l; m_periodic = p;
        m_left = (r == 0) ? 1 : r;
      end
    end else if (ab) begin
      m_job = 0;
    end else if (m_wrap_up) begin
      m_job = 0;
      m_wrap_up = 0;
    end else if (m_need_load) begin
      m_count = m_start;
      m_need_load = 0;
    end else if (!ps) begin
      if (m_count == m_limit) begin
        m_count = m_start;
        m_tick = 1;
        if (!m_periodic) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_wrap_up = 1;
            m_done = 1;
          end
        end
      end else begin
        m_count = (m_count + 1) % 256;
      end
    end
  endfunction

  int exp_wrap[5];
  int done_seen;
  int rv_valid, rv_start, rv_limit, rv_per, rv_reps, rv_pause, rv_abort;

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_start = '0; cfg_limit = '0;
    cfg_periodic = 1'b0; cfg_reps = '0; pause = 1'b0; abort = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 2};
    vecs[1] = '{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 2};
    vecs[2] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 2};
    vecs[3] = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 2};
    vecs[4] = '{1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1, 1};
    vecs[5] = '{1'b0, 1'b0, 4, 1'b0, 1'b0, 1'b1, 1};
    vecs[6] = '{1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b1, 1};
    vecs[7] = '{1'b0, 1'b0, 6, 1'b0, 1'b0, 1'b1, 1};
    vecs[8] = '{1'b0, 1'b0, 3, 1'b1, 1'b1, 1'b1, 0};
    vecs[9] = '{1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b0, 0};

    exp_wrap = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'hFE};

    // Reset state
    #12;
    check("rst_busy", busy, 0);
    check("rst_count", count, 0);
    check("rst_tick", tick, 0);
    check("rst_done", done, 0);
    check("rst_rep_left", rep_left, 0);
    rst_n = 1'b1;
    cycle();
    check("rst_cfg_ready", cfg_ready, 1);

    // One-shot basic, table-driven
    wait_ready();
    drive_cfg(3, 6, 0, 2);
    cycle();
    cfg_valid = 1'b0;
    check("t2_load_busy", busy, 1);
    check("t2_load_ready", cfg_ready, 0);
    for (int i = 0; i < 10; i++) begin
      pause = vecs[i].pause;
      abort = vecs[i].abort;
      cycle();
      check($sformatf("t2_count[%0d]", i), count, vecs[i].exp_count);
      check($sformatf("t2_tick[%0d]", i), tick, vecs[i].exp_tick);
      check($sformatf("t2_done[%0d]", i), done, vecs[i].exp_done);
      check($sformatf("t2_busy[%0d]", i), busy, vecs[i].exp_busy);
      check($sformatf("t2_rep[%0d]", i), rep_left, vecs[i].exp_rep);
    end
    pause = 1'b0; abort = 1'b0;

    // Wrap-around through 0xFF -> 0x00
    wait_ready();
    drive_cfg(8'hFE, 8'h01, 0, 1);
    cycle();
    cfg_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check($sformatf("t3_count[%0d]", i), count, exp_wrap[i]);
      check($sformatf("t3_tick[%0d]", i), tick, (i == 4) ? 1 : 0);
      check($sformatf("t3_done[%0d]", i), done, (i == 4) ? 1 : 0);
    end
    cycle();
    check("t3_idle", busy, 0);

    // Periodic with a two-cycle pause at count 1
    wait_ready();
    drive_cfg(0, 2, 1, 0);
    cycle();
    cfg_valid = 1'b0;
    done_seen = 0;
    cycle(); check("t4_c0", count, 0);
    cycle(); check("t4_c1", count, 1);
    pause = 1'b1;
    cycle(); check("t4_hold_a", count, 1); check("t4_hold_a_tick", tick, 0);
    cycle(); check("t4_hold_b", count, 1);
    pause = 1'b0;
    cycle(); check("t4_c2", count, 2); check("t4_c2_tick", tick, 0);
    cycle(); check("t4_tick1_count", count, 0); check("t4_tick1", tick, 1);
    done_seen += int'(done);
    cycle(); check("t4_c1b", count, 1); check("t4_c1b_tick", tick, 0);
    cycle(); check("t4_c2b", count, 2);
    cycle(); check("t4_tick2_count", count, 0); check("t4_tick2", tick, 1);
    done_seen += int'(done);
    check("t4_busy", busy, 1);
    check("t4_no_done", done_seen, 0);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t4_abort_idle", busy, 0);
    check("t4_abort_count", count, 0);

    // Abort on the terminal cycle of the final period
    wait_ready();
    drive_cfg(3, 5, 0, 1);
    cycle();
    cfg_valid = 1'b0;
    cycle(); cycle(); cycle();
    check("t5_at_limit", count, 5);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_ready", cfg_ready, 1);
    check("t5_tick", tick, 0);
    check("t5_done", done, 0);
    check("t5_count", count, 5);
    check("t5_rep", rep_left, 1);
    cycle();
    check("t5_tick_after", tick, 0);
    check("t5_done_after", done, 0);
    check("t5_count_after", count, 5);

    // reps=0 gives one period; a held cfg_valid is taken right after DONE
    wait_ready();
    drive_cfg(7, 8, 0, 0);
    cycle();
    drive_cfg(8'h10, 8'h11, 0, 1);
    done_seen = 0;
    check("t6_rep_norm", rep_left, 1);
    check("t6_ready_load", cfg_ready, 0);
    cycle(); check("t6_c7", count, 7); check("t6_ready_run", cfg_ready, 0);
    done_seen += int'(done);
    cycle(); check("t6_c8", count, 8);
    done_seen += int'(done);
    cycle(); check("t6_done_count", count, 7); check("t6_done", done, 1);
    check("t6_tick", tick, 1); check("t6_ready_done", cfg_ready, 0);
    done_seen += int'(done);
    cycle(); check("t6_idle_busy", busy, 0); check("t6_idle_ready", cfg_ready, 1);
    check("t6_idle_count", count, 7);
    done_seen += int'(done);
    cycle(); check("t6_b2b_busy", busy, 1); check("t6_b2b_rep", rep_left, 1);
    done_seen += int'(done);
    cfg_valid = 1'b0;
    check("t6_one_done", done_seen, 1);
    cycle(); check("t6_b2b_count", count, 8'h10);

    // Reset in the middle of a running job
    rst_n = 1'b0;
    #1;
    check("t1_busy", busy, 0);
    check("t1_count", count, 0);
    check("t1_tick", tick, 0);
    check("t1_done", done, 0);
    check("t1_rep", rep_left, 0);
    #2 rst_n = 1'b1;
    cycle();
    check("t1_ready", cfg_ready, 1);
    check("t1_busy_after", busy, 0);

    // Randomized traffic against the reference model
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      rv_valid = ($urandom_range(0, 2) == 0) ? 1 : 0;
      rv_start = $urandom_range(0, 255);
      rv_limit = (rv_start + $urandom_range(0, 5)) % 256;
      rv_per   = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv_reps  = $urandom_range(0, 3);
      rv_pause = ($urandom_range(0, 3) == 0) ? 1 : 0;
      rv_abort = ($urandom_range(0, 39) == 0) ? 1 : 0;
      drive_cfg(rv_start, rv_limit, rv_per, rv_reps);
      cfg_valid = 1'(rv_valid);
      pause     = 1'(rv_pause);
      abort     = 1'(rv_abort);
      model_edge(rv_valid[0], rv_start, rv_limit, rv_per[0], rv_reps, rv_pause[0], rv_abort[0]);
      cycle();
      check($sformatf("rnd_count[%0d]", n), count, m_count);
      check($sformatf("rnd_tick[%0d]", n), tick, m_tick);
      check($sformatf("rnd_done[%0d]", n), done, m_done);
      check($sformatf("rnd_busy[%0d]", n), busy, m_job);
      check($sformatf("rnd_ready[%0d]", n), cfg_ready, !m_job);
      check($sformatf("rnd_rep[%0d]", n), rep_left, m_left);
    end
    cfg_valid = 1'b0; pause = 1'b0; abort = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
